// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order imem reads under a credit limit, buffers words, drives IF/ID.
// Optional jump predecode redirect is compiled in with `define FETCH_JUMP_PREDECODE_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        StallD,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcp4;
  } fentry_t;

  logic [31:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outst_q, outst_d, drop_q, drop_d, count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [31:0]   instr_q, instr_d, pcp4_q, pcp4_d;
  logic          valid_q, valid_d;
  fentry_t       fifo_q [FIFO_DEPTH];

  logic          credit_ok, accept, rsp_live, rsp_take, fifo_nempty;
  logic          load_en, bypass, push, pop, jump_redir, redirect;
  logic [31:0]   jump_tgt, redir_tgt;
  fentry_t       load_dat, rsp_ent;

  always_comb begin
    credit_ok      = ({1'b0, outst_q} + {1'b0, count_q}) < (CW+1)'(FIFO_DEPTH);
    // Held low while in reset so memory never sees a request from a resetting stage.
    imem_req_valid = rst_n && credit_ok && !PCSrcD;
    imem_req_addr  = fetch_pc_q;
    accept         = imem_req_valid && imem_req_ready;
    rsp_live       = imem_rsp_valid && (drop_q == '0);
    fifo_nempty    = (count_q != '0);
    rsp_ent        = '{instr: imem_rsp_data, pcp4: rsp_pc_q + 32'd4};
    load_en        = !PCSrcD && !StallD && (fifo_nempty || rsp_live);
    load_dat       = fifo_nempty ? fifo_q[rd_ptr_q] : rsp_ent;
`ifdef FETCH_JUMP_PREDECODE_EN
    jump_redir     = load_en && (load_dat.instr[31:26] == 6'b000010);
    jump_tgt       = {load_dat.pcp4[31:28], load_dat.instr[25:0], 2'b00};
`else
    jump_redir     = 1'b0;
    jump_tgt       = 32'h0;
`endif
    redirect       = PCSrcD || jump_redir;
    redir_tgt      = PCSrcD ? (PCBranchD & ~32'h3) : jump_tgt;
    // A word arriving behind a jump popped from the FIFO is already wrong-path.
    rsp_take       = rsp_live && !PCSrcD && !(jump_redir && fifo_nempty);
    bypass         = rsp_take && !fifo_nempty && !StallD;
    push           = rsp_take && !bypass;
    pop            = load_en && fifo_nempty;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    outst_d    = outst_q + CW'(accept) - CW'(imem_rsp_valid);
    drop_d     = drop_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    instr_d    = instr_q;
    pcp4_d     = pcp4_q;
    valid_d    = valid_q;

    if (redirect) begin
      fetch_pc_d = redir_tgt;
      rsp_pc_d   = redir_tgt;
      drop_d     = outst_d;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (accept)                          fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_take)                        rsp_pc_d   = rsp_pc_q + 32'd4;
      if (imem_rsp_valid && drop_q != '0)  drop_d     = drop_q - 1'b1;
      if (push)                            wr_ptr_d   = wr_ptr_q + 1'b1;
      if (pop)                             rd_ptr_d   = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end

    if (PCSrcD) begin
      instr_d = 32'h0;
      valid_d = 1'b0;
    end else if (!StallD) begin
      if (load_en) begin
        instr_d = load_dat.instr;
        pcp4_d  = load_dat.pcp4;
        valid_d = 1'b1;
      end else begin
        instr_d = 32'h0;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      instr_q    <= 32'h0;
      pcp4_q     <= 32'h0;
      valid_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      instr_q    <= instr_d;
      pcp4_q     <= pcp4_d;
      valid_q    <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= rsp_ent;
  end

  assign InstrD   = instr_q;
  assign PCPlus4D = pcp4_q;
  assign ValidD   = valid_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(rsp_live && count_q == CW'(FIFO_DEPTH)));

endmodule
